// File: rtl/mm_pkg.sv
// Shared types and default dimensions for the matrix-multiply accumulate controller.
package mm_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_WRITE  = 3'd3,
        S_FINISH = 3'd4
    } mm_state_e;

    localparam int DEF_N_INNER     = 8;
    localparam int DEF_C_ROWS      = 8;
    localparam int DEF_C_COLS      = 8;
    localparam int DEF_C_MEM_DEPTH = 64;
    localparam int DEF_WIDTH       = 32;

    // Counter width for 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_acc_controller_if.sv
// Operand, multiplier and result-memory signals between the controller and its datapath.
interface mult_acc_controller_if
    import mm_pkg::*;
#(
    parameter int W  = DEF_WIDTH,
    parameter int AW = $clog2(DEF_C_MEM_DEPTH)
);
    // Operand handshake: a pair transfers on a rising edge where op_valid and
    // op_ready are both high; the source holds op_a/op_b stable while waiting.
    logic          op_valid;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          op_ready;

    logic [W-1:0]  mult_a;
    logic [W-1:0]  mult_b;
    logic          mult_start;
    logic [W-1:0]  mult_out;
    logic          mult_done;

    logic          wr_en;
    logic [AW-1:0] wr_address;
    logic [W-1:0]  wr_data;

    modport master (
        input  op_valid, op_a, op_b,
        output op_ready,
        output mult_a, mult_b, mult_start,
        input  mult_out, mult_done,
        output wr_en, wr_address, wr_data
    );

    modport slave (
        output op_valid, op_a, op_b,
        input  op_ready,
        input  mult_a, mult_b, mult_start,
        output mult_out, mult_done,
        input  wr_en, wr_address, wr_data
    );

endinterface

// File: rtl/mm_index_counter.sv
// Row-major row/column walker over the result matrix with last-element flag and flat address.
module mm_index_counter
    import mm_pkg::*;
#(
    parameter int ROWS = DEF_C_ROWS,
    parameter int COLS = DEF_C_COLS,
    parameter int AW   = $clog2(DEF_C_MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic          last_o,
    output logic [AW-1:0] addr_o
);
    localparam int RW = idx_width(ROWS);
    localparam int CW = idx_width(COLS);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          row_end;
    logic          col_end;

    assign row_end = (row_q == RW'(ROWS - 1));
    assign col_end = (col_q == CW'(COLS - 1));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (adv_i) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign last_o = row_end && col_end;
    // Address arithmetic is done at port width, so oversized products truncate.
    assign addr_o = AW'(row_q) * AW'(COLS) + AW'(col_q);

endmodule

// File: rtl/mult_acc_controller.sv
// Sequences operand pairs through an external multiplier, accumulates each dot product and writes C.
module mult_acc_controller
    import mm_pkg::*;
#(
    parameter int N_INNER          = DEF_N_INNER,
    parameter int C_ROWS           = DEF_C_ROWS,
    parameter int C_COLS           = DEF_C_COLS,
    parameter int C_MEM_DEPTH      = DEF_C_MEM_DEPTH,
    parameter int MATRIX_MEM_WIDTH = DEF_WIDTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      start,
    output logic      busy,
    output logic      done,
    output mm_state_e state_dbg,
    mult_acc_controller_if.master bus
);
    localparam int AW = $clog2(C_MEM_DEPTH);
    localparam int KW = idx_width(N_INNER);
    localparam int W  = MATRIX_MEM_WIDTH;

    mm_state_e     state_q, state_d;
    logic [W-1:0]  acc_q;
    logic [KW-1:0] k_q;
    logic [W-1:0]  mult_a_q, mult_b_q;
    logic          mult_start_q;

    logic          take_op;
    logic          take_prod;
    logic          k_last;
    logic          idx_last;
    logic [AW-1:0] idx_addr;

    assign take_op   = (state_q == S_ISSUE) && bus.op_valid;
    assign take_prod = (state_q == S_WAIT) && bus.mult_done;
    assign k_last    = (k_q == KW'(N_INNER - 1));

    mm_index_counter #(
        .ROWS (C_ROWS),
        .COLS (C_COLS),
        .AW   (AW)
    ) u_index (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == S_FINISH),
        .adv_i  (state_q == S_WRITE),
        .last_o (idx_last),
        .addr_o (idx_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ISSUE;
            S_ISSUE:  if (bus.op_valid) state_d = S_WAIT;
            S_WAIT:   if (bus.mult_done) state_d = k_last ? S_WRITE : S_ISSUE;
            S_WRITE:  state_d = idx_last ? S_FINISH : S_ISSUE;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_FINISH);
        bus.op_ready   = (state_q == S_ISSUE);
        bus.wr_en      = 1'b0;
        bus.wr_data    = '0;
        bus.wr_address = '0;
        if (state_q == S_WRITE) begin
            bus.wr_en      = 1'b1;
            bus.wr_data    = acc_q;
            bus.wr_address = idx_addr;
        end
    end

    // Accumulator wraps modulo 2^W; the carry out is intentionally dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            k_q          <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            mult_start_q <= 1'b0;
        end else begin
            mult_start_q <= take_op;
            if (take_op) begin
                mult_a_q <= bus.op_a;
                mult_b_q <= bus.op_b;
            end
            if (take_prod) begin
                acc_q <= acc_q + bus.mult_out;
                k_q   <= k_q + 1'b1;
            end else if (state_q == S_WRITE) begin
                acc_q <= '0;
                k_q   <= '0;
            end
        end
    end

    assign bus.mult_a     = mult_a_q;
    assign bus.mult_b     = mult_b_q;
    assign bus.mult_start = mult_start_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_mult_acc_controller.sv
// Directed-random bench: operand feeder, 3-cycle multiplier model, result scoreboard.
module tb_mult_acc_controller;
    import mm_pkg::*;

    localparam int N  = 2;
    localparam int R  = 2;
    localparam int C  = 2;
    localparam int W  = 32;
    localparam int AW = 6;

    logic      clk;
    logic      rst;
    logic      start;
    logic      busy;
    logic      done;
    mm_state_e state_dbg;

    mult_acc_controller_if #(.W(W), .AW(AW)) bus ();

    mult_acc_controller #(
        .N_INNER          (N),
        .C_ROWS           (R),
        .C_COLS           (C),
        .C_MEM_DEPTH      (64),
        .MATRIX_MEM_WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg),
        .bus       (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int wr_cnt   = 0;

    logic [W-1:0]  exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [W-1:0]  pair_a_q[$];
    logic [W-1:0]  pair_b_q[$];

    bit feed_en      = 1'b0;
    bit fire_pending = 1'b0;
    int spur_req_n   = 0;
    int spur_done_n  = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: C[e] is the wrapped sum of the element's products, row-major addresses.
    task automatic plan_matrix(input bit wrap_first);
        for (int e = 0; e < R * C; e++) begin
            logic [W-1:0] sum = '0;
            for (int k = 0; k < N; k++) begin
                logic [W-1:0] a = $urandom;
                logic [W-1:0] b = $urandom;
                if (wrap_first && e == 0) begin
                    a = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_0002;
                    b = 32'h0000_0001;
                end
                pair_a_q.push_back(a);
                pair_b_q.push_back(b);
                sum = sum + a * b;
            end
            exp_q.push_back(sum);
            exp_addr_q.push_back(AW'(e));
        end
    endtask

    // Operand source: raises valid at random, holds the pair until it is accepted.
    always @(negedge clk) begin
        if (fire_pending && pair_a_q.size() > 0) begin
            void'(pair_a_q.pop_front());
            void'(pair_b_q.pop_front());
            bus.op_valid = 1'b0;
        end
        if (!feed_en || pair_a_q.size() == 0) begin
            bus.op_valid = 1'b0;
        end else if (bus.op_valid !== 1'b1 && $urandom_range(0, 3) != 0) begin
            bus.op_valid = 1'b1;
            bus.op_a     = pair_a_q[0];
            bus.op_b     = pair_b_q[0];
        end
        fire_pending = (bus.op_valid === 1'b1) && (bus.op_ready === 1'b1);
    end

    // Multiplier model, latency 3; can also inject a stray done while the controller issues.
    int           mul_cnt  = -1;
    logic [W-1:0] mul_prod = '0;
    always @(negedge clk) begin
        bus.mult_done = 1'b0;
        bus.mult_out  = '0;
        if (mul_cnt > 0) mul_cnt--;
        if (mul_cnt == 0) begin
            bus.mult_done = 1'b1;
            bus.mult_out  = mul_prod;
            mul_cnt       = -1;
        end else if (spur_req_n != spur_done_n && bus.op_ready === 1'b1) begin
            bus.mult_done = 1'b1;
            bus.mult_out  = 32'hDEAD_BEEF;
            spur_done_n   = spur_req_n;
        end
        if (bus.mult_start === 1'b1) begin
            mul_prod = bus.mult_a * bus.mult_b;
            mul_cnt  = 2;
        end
    end

    // Result scoreboard.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wr_cnt++;
            check("wr_expected", W'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                check("wr_address", W'(bus.wr_address), W'(exp_addr_q.pop_front()));
                check("wr_data", bus.wr_data, exp_q.pop_front());
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            check("done_after_last_write", W'(exp_q.size()), 0);
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int d0, input int w0);
        for (int i = 0; i < 600 && done_cnt == d0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, W'(done_cnt - d0), 1);
        check({tag, "_writes"}, W'(wr_cnt - w0), W'(R * C));
        check({tag, "_idle"}, W'(busy), 0);
    endtask

    int d0;
    int w0;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", W'(state_dbg), W'(S_IDLE));
        check("rst_busy", W'(busy), 0);
        check("rst_done", W'(done), 0);
        check("rst_op_ready", W'(bus.op_ready), 0);
        check("rst_mult_start", W'(bus.mult_start), 0);
        check("rst_mult_a", bus.mult_a, 0);
        check("rst_mult_b", bus.mult_b, 0);
        check("rst_wr_en", W'(bus.wr_en), 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_wr_address", W'(bus.wr_address), 0);
        rst = 1'b0;
        @(negedge clk);

        // Fixed pairs (1,2),(3,4): every element is 14; start during FINISH is ignored.
        for (int e = 0; e < R * C; e++) begin
            pair_a_q.push_back(1); pair_b_q.push_back(2);
            pair_a_q.push_back(3); pair_b_q.push_back(4);
            exp_q.push_back(14);
            exp_addr_q.push_back(AW'(e));
        end
        feed_en = 1'b1;
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        for (int i = 0; i < 600 && state_dbg != S_FINISH; i++) @(negedge clk);
        check("fixed_reach_finish", W'(state_dbg), W'(S_FINISH));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_finish_ignored", W'(state_dbg), W'(S_IDLE));
        finish_run("fixed", d0, w0);

        // Operands withheld in ISSUE: ready stays up, nothing launches, state holds.
        feed_en = 1'b0;
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        for (int i = 0; i < 20 && state_dbg != S_ISSUE; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_op_ready", W'(bus.op_ready), 1);
            check("hold_no_mult_start", W'(bus.mult_start), 0);
            check("hold_state", W'(state_dbg), W'(S_ISSUE));
        end
        plan_matrix(1'b0);
        feed_en = 1'b1;
        finish_run("withhold", d0, w0);

        // Products 0xFFFFFFFF + 2 wrap to 1 at address 0.
        plan_matrix(1'b1);
        check("wrap_model", exp_q[0], 32'h0000_0001);
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        finish_run("wrap", d0, w0);

        // Stray mult_done in ISSUE and a second start while busy change nothing.
        plan_matrix(1'b0);
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        repeat (4) @(negedge clk);
        spur_req_n++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("spurious_injected", W'(spur_done_n), W'(spur_req_n));
        finish_run("spurious", d0, w0);

        // Reset while waiting on element 2's product aborts the run.
        plan_matrix(1'b0);
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        for (int i = 0; i < 600 && !(wr_cnt == w0 + 1 && state_dbg == S_WAIT); i++) @(negedge clk);
        check("abort_in_wait", W'(state_dbg), W'(S_WAIT));
        #1 rst = 1'b1;
        #1;
        check("abort_state", W'(state_dbg), W'(S_IDLE));
        check("abort_busy", W'(busy), 0);
        check("abort_op_ready", W'(bus.op_ready), 0);
        check("abort_mult_a", bus.mult_a, 0);
        check("abort_wr_en", W'(bus.wr_en), 0);
        feed_en = 1'b0;
        pair_a_q.delete();
        pair_b_q.delete();
        exp_q.delete();
        exp_addr_q.delete();
        repeat (6) @(negedge clk);
        check("abort_no_done", W'(done_cnt - d0), 0);
        check("abort_no_write", W'(wr_cnt - w0), 1);
        rst = 1'b0;
        @(negedge clk);
        plan_matrix(1'b0);
        feed_en = 1'b1;
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        finish_run("restart", d0, w0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
